// File: rtl/spi_master_multi.sv
// spi_master_multi: parametrised SPI master, CPOL/CPHA at runtime, N selects.
// Optional LSB-first transfers via `SPI_MASTER_LSB_FIRST_EN (adds lsb_first).
module spi_master_multi #(
  parameter int DATA_W  = 8,
  parameter int NUM_SS  = 2,
  parameter int CLK_DIV = 2,
  parameter int SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic [1:0]                    mode,
  input  logic [SEL_W-1:0]              ss_sel,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic                          lsb_first,
`endif
  input  logic                          miso,
  output logic                          mosi,
  output logic                          sclk,
  output logic [NUM_SS-1:0]             ss_n,
  output logic                          busy,
  output logic                          done,
  output logic [DATA_W-1:0]             rx_data,
  output logic [$clog2(DATA_W+1)-1:0]   counter
);

  localparam int EDGES  = 2 * DATA_W;
  localparam int EDGE_W = $clog2(EDGES + 1);
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, XFER, HOLD, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rxd_q, rxd_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                mosi_q, mosi_d;
  logic                sclk_q, sclk_d;
  logic                cpha_q, cpha_d;
  logic                lsb_q, lsb_d;

  logic lsb_in;
  logic tick, fire, lead, smp, shf, accept;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  // Edge timing: SETUP end gives edge 1, each XFER block end the rest.
  assign tick = (div_q == DIV_W'(CLK_DIV - 1));
  assign fire = tick && ((state_q == SETUP) ||
                ((state_q == XFER) && (edge_q != EDGE_W'(EDGES))));
  assign lead = ~edge_q[0];
  assign smp  = lead ^ cpha_q;
  assign shf  = cpha_q ? lead :
                (!lead && (edge_q != EDGE_W'(EDGES - 1)));

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxd_q   <= '0;
      sel_q   <= '0;
      mosi_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxd_q   <= rxd_d;
      sel_q   <= sel_d;
      mosi_q  <= mosi_d;
      sclk_q  <= sclk_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
    end
  end

  // Next-state, SCLK edges, shift/sample and accept handling.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    edge_d  = edge_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxd_d   = rxd_q;
    sel_d   = sel_q;
    mosi_d  = mosi_q;
    sclk_d  = sclk_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: accept = start;
      SETUP: begin
        div_d = div_q + 1'b1;
        if (tick) begin
          div_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        div_d = div_q + 1'b1;
        if (tick) begin
          div_d = '0;
          if (edge_q == EDGE_W'(EDGES)) state_d = HOLD;
        end
      end
      HOLD: begin
        div_d = div_q + 1'b1;
        if (tick) begin
          div_d   = '0;
          state_d = DONE;
          rxd_d   = rx_q;
          mosi_d  = 1'b0;
        end
      end
      DONE: begin
        accept  = start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fire) begin
      sclk_d = ~sclk_q;
      edge_d = edge_q + 1'b1;
      if (smp) begin
        cnt_d = cnt_q + 1'b1;
        rx_d  = lsb_q ? {miso, rx_q[DATA_W-1:1]}
                      : {rx_q[DATA_W-2:0], miso};
      end
      if (shf) begin
        mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
        tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
      end
    end
    if (accept) begin
      state_d = SETUP;
      div_d   = '0;
      edge_d  = '0;
      cnt_d   = '0;
      rx_d    = '0;
      sel_d   = ss_sel;
      cpha_d  = mode[0];
      lsb_d   = lsb_in;
      sclk_d  = mode[1];
      if (mode[0]) begin
        mosi_d = 1'b0;
        tx_d   = tx_data;
      end else begin
        mosi_d = lsb_in ? tx_data[0] : tx_data[DATA_W-1];
        tx_d   = lsb_in ? (tx_data >> 1) : (tx_data << 1);
      end
    end
  end

  // One-hot-low select for the latched slave; out-of-range selects none.
  always_comb begin
    ss_n = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (busy && (sel_q == SEL_W'(i))) ss_n[i] = 1'b0;
    end
  end

  assign busy    = (state_q == SETUP) || (state_q == XFER) ||
                   (state_q == HOLD);
  assign done    = (state_q == DONE);
  assign mosi    = mosi_q;
  assign sclk    = sclk_q;
  assign rx_data = rxd_q;
  assign counter = cnt_q;

endmodule

// File: doc/spi_master_multi.md
# spi_master_multi

Parametrised SPI master, successor to the fixed 8-bit, two-select `spi_master`. It serialises one `DATA_W`-bit word per `start` request and captures the word returned on `miso`. It supports all four CPOL/CPHA modes, selectable at runtime, and an SCLK divider set at build time. It drives one of `NUM_SS` active-low slave selects and sits between the system-side register logic and the FPGA SPI pins.

## Interface
- `DATA_W`, 8, word length in bits, ≥2
- `NUM_SS`, 2, number of slave-select lines, ≥1
- `CLK_DIV`, 2, `clk` cycles per SCLK half-period, ≥1
- `SEL_W`, `$clog2(NUM_SS)` (min 1), width of `ss_sel`
- `clk`  in  1  system clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  transfer request, sampled only when `busy`=0
- `tx_data`  in  DATA_W  word to send, latched on accepted `start`
- `mode`  in  2  {CPOL,CPHA}, latched on accepted `start`
- `ss_sel`  in  SEL_W  slave index, latched on accepted `start`
- `miso`  in  1  serial data from slave
- `mosi`  out  1  serial data to slave
- `sclk`  out  1  SPI clock
- `ss_n`  out  NUM_SS  active-low selects, one-hot-low while busy
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle pulse, transfer complete
- `rx_data`  out  DATA_W  last received word, valid from `done`
- `counter`  out  $clog2(DATA_W+1)  bits sampled so far in current transfer

## Operation
- FSM states:
  - IDLE: waits for `start`.
  - SETUP: lasts `CLK_DIV` cycles.
  - XFER: lasts 2·DATA_W·CLK_DIV cycles, one SCLK edge every `CLK_DIV` cycles.
  - HOLD: lasts `CLK_DIV` cycles.
  - DONE: lasts 1 cycle, then returns to IDLE, or to SETUP if `start` is high.
- Accepted `start` (IDLE or DONE) latches `tx_data`, `mode` and `ss_sel`. Input changes after that are ignored until the next accept.
- Leading edge is the first SCLK edge after SETUP; edges then alternate trailing and leading.
- CPHA=0:
  - First bit drives `mosi` on SETUP entry.
  - `miso` is sampled on leading edges.
  - `mosi` shifts on trailing edges, except after the final edge.
- CPHA=1:
  - `mosi` shifts on leading edges; the first leading edge drives the first bit.
  - `miso` is sampled on trailing edges.
- MSB first; received bits shift in at the LSB.
- `counter` increments on each sample edge and reaches DATA_W on the last one. It holds in HOLD and DONE, and clears on the next accept.
- `sclk` idles at the latched CPOL and toggles only in XFER.
- `ss_n[ss_sel]` is low from SETUP through HOLD and high in DONE. If `ss_sel` ≥ NUM_SS, all `ss_n` stay high and the transfer still runs.
- `start` while `busy`=1 is ignored; there is no queueing.

## Timing
- Reset values: `sclk`=0, `mosi`=0, `ss_n`=all 1, `busy`=0, `done`=0, `rx_data`=0, `counter`=0, latched mode=0.
- `rst` mid-transfer: all outputs take their reset values at the next edge. No partial `done` is produced and `rx_data` is cleared.
- Cycle numbering: the accepted `start` is sampled at the edge ending cycle 0.
  - `busy`=1 and the select is low from cycle 1.
  - `done`=1 in cycle 1+(2·DATA_W+2)·CLK_DIV, with `busy`=0 in that cycle.
  - `rx_data` updates in the same cycle as `done`.
- Defaults: `done` at cycle 37.
- Back-to-back: `start` high in the DONE cycle begins SETUP in the next cycle. `ss_n` is high for exactly 1 cycle between transfers.
- `mosi` returns to 0 in DONE.
- In IDLE, `sclk` holds the CPOL of the most recent transfer.

## Configuration
- `SPI_MASTER_LSB_FIRST_EN`:
  - Defined: adds input port `lsb_first` (1 bit), latched on accepted `start`. When 1, bit 0 is sent first and received bits shift in from the MSB, so `rx_data` is still presented in natural bit order.
  - Undefined: the port is absent and transfers are always MSB first.

## Test plan
- Reset, defaults, mode 0:
  - Stimulus: hold `rst` 3 cycles; `start` with `tx_data`=0xA5, slave returns 0x3C on `miso`.
  - Required: `mosi` sequence 1,0,1,0,0,1,0,1; `ss_n`=2'b10 for 36 cycles; `done` at cycle 37; `rx_data`=0x3C; `counter`=8.
- All four modes, `CLK_DIV`=1, slave model per mode, `tx_data`=0x81:
  - Required: `sclk` idle level equals CPOL.
  - Required: sample and shift edges as specified.
  - Required: `rx_data` matches the slave word in every mode.
- Back-to-back and ignored start:
  - Stimulus: `start` held high continuously; two transfers to `ss_sel`=0 then 1.
  - Required: `ss_n` goes 2'b10 → 2'b11 for 1 cycle → 2'b01.
  - Required: a `start` pulse mid-transfer changes nothing.
- Reset mid-transfer:
  - Stimulus: assert `rst` at cycle 10.
  - Required: next cycle `ss_n` all 1, `sclk`=0, `busy`=0, `rx_data`=0, no `done`.
- Out-of-range select and parameters:
  - Stimulus: `NUM_SS`=3 with `ss_sel`=3; separately `DATA_W`=16, `CLK_DIV`=3.
  - Required: `ss_n`=3'b111 throughout with `done` still pulsing; `done` at cycle 1+34·3=103.
- With `SPI_MASTER_LSB_FIRST_EN`:
  - Stimulus: `lsb_first`=1, `tx_data`=0x01.
  - Required: first `mosi` bit=1; slave sending 0x80 LSB-first yields `rx_data`=0x80.
